// File: rtl/wvb_storage_gen2_if.sv
`default_nettype none
// ============================================================================
// wvb_storage_gen2_if : port bundle between the waveform buffer write
//                       controller / DAQ reader and wvb_storage_gen2
// Revision 1.0
// ============================================================================
interface wvb_storage_gen2_if #(
    parameter int P_DATA_WIDTH         = 22,
    parameter int P_ADR_WIDTH          = 12,
    parameter int P_HDR_WIDTH          = 80,
    parameter int P_N_WVF_IN_BUF_WIDTH = 16
);
    logic [P_DATA_WIDTH-1:0]         wvb_data_in;
    logic                            eoe_in;
    logic [P_ADR_WIDTH-1:0]          wvb_wr_addr;
    logic                            wvb_wrreq;
    logic [P_ADR_WIDTH-1:0]          wvb_rd_addr;
    logic [P_DATA_WIDTH-1:0]         wvb_data_out;
    logic [P_HDR_WIDTH-1:0]          hdr_data_in;
    logic                            hdr_wrreq;
    logic                            hdr_rdreq;
    logic [P_HDR_WIDTH-1:0]          hdr_data_out;
    logic                            hdr_full;
    logic                            hdr_empty;
    logic                            hdr_almost_full;
    logic [P_N_WVF_IN_BUF_WIDTH-1:0] n_wvf_in_buf;
    logic                            hdr_ovf;
    logic                            hdr_unf;
    logic [15:0]                     hdr_drop_cnt;
    logic                            err_clr;

    modport master (
        output wvb_data_in, eoe_in, wvb_wr_addr, wvb_wrreq, wvb_rd_addr,
               hdr_data_in, hdr_wrreq, hdr_rdreq, err_clr,
        input  wvb_data_out, hdr_data_out, hdr_full, hdr_empty, hdr_almost_full,
               n_wvf_in_buf, hdr_ovf, hdr_unf, hdr_drop_cnt
    );

    modport slave (
        input  wvb_data_in, eoe_in, wvb_wr_addr, wvb_wrreq, wvb_rd_addr,
               hdr_data_in, hdr_wrreq, hdr_rdreq, err_clr,
        output wvb_data_out, hdr_data_out, hdr_full, hdr_empty, hdr_almost_full,
               n_wvf_in_buf, hdr_ovf, hdr_unf, hdr_drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/wvb_storage_gen2.sv
`default_nettype none
// ============================================================================
// wvb_storage_gen2 : mDOM waveform sample RAM + header FIFO with error tracking
//                    (WVB_STORAGE_HDR_FWFT_EN selects first-word-fall-through)
// Revision 1.0
// ============================================================================
module wvb_storage_gen2 #(
    parameter int P_DATA_WIDTH         = 22,
    parameter int P_ADR_WIDTH          = 12,
    parameter int P_HDR_WIDTH          = 80,
    parameter int P_HDR_ADR_WIDTH      = 8,
    parameter int P_N_WVF_IN_BUF_WIDTH = 16,
    parameter int P_AFULL_THRESH       = 240
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    wvb_storage_gen2_if.slave bus
);
    localparam int                 L_WVB_DEPTH = 1 << P_ADR_WIDTH;
    localparam int                 L_HDR_DEPTH = 1 << P_HDR_ADR_WIDTH;
    localparam int                 L_CNT_W     = P_HDR_ADR_WIDTH + 1;
    localparam logic [L_CNT_W-1:0] L_CNT_FULL  = L_CNT_W'(L_HDR_DEPTH);
    localparam logic [15:0]        L_DROP_MAX  = 16'hFFFF;
`ifdef WVB_STORAGE_HDR_FWFT_EN
    localparam logic [L_CNT_W-1:0] L_CNT_ONE   = L_CNT_W'(1);
`endif

    generate
        if (P_N_WVF_IN_BUF_WIDTH < P_HDR_ADR_WIDTH + 1) begin : g_bad_cnt_width
            $error("P_N_WVF_IN_BUF_WIDTH must be >= P_HDR_ADR_WIDTH+1");
        end
    endgenerate

    // ---------------- sample RAM (read-first, 1-clk latency) ----------------
    logic [P_DATA_WIDTH-1:0] wvb_mem [L_WVB_DEPTH];
    logic [P_DATA_WIDTH-1:0] wvb_rd_q;
    logic                    w_unused_din0;

    assign w_unused_din0 = bus.wvb_data_in[0];

    always_ff @(posedge clk) begin
        if (bus.wvb_wrreq) begin
            wvb_mem[bus.wvb_wr_addr] <= {bus.wvb_data_in[P_DATA_WIDTH-1:1], bus.eoe_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvb_rd_q <= '0;
        end else begin
            wvb_rd_q <= wvb_mem[bus.wvb_rd_addr];
        end
    end

    // ---------------- header FIFO ----------------
    logic [P_HDR_WIDTH-1:0]     hdr_mem [L_HDR_DEPTH];
    logic [P_HDR_ADR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, w_rd_ptr_nxt;
    logic [L_CNT_W-1:0]         cnt_q, cnt_d;
    logic [P_HDR_WIDTH-1:0]     hdr_out_q, hdr_out_d;
    logic                       ovf_q, ovf_d, unf_q, unf_d;
    logic [15:0]                drop_q, drop_d;
    logic                       w_full, w_empty, w_push_ok, w_pop_ok, w_push_drop, w_pop_ign;

    always_comb begin
        w_full       = (cnt_q == L_CNT_FULL);
        w_empty      = (cnt_q == '0);
        // Full blocks only the push and empty only the pop, so a combined
        // request at either boundary degrades to the single legal operation.
        w_push_ok    = bus.hdr_wrreq & ~w_full;
        w_pop_ok     = bus.hdr_rdreq & ~w_empty;
        w_push_drop  = bus.hdr_wrreq & w_full;
        w_pop_ign    = bus.hdr_rdreq & w_empty;
        w_rd_ptr_nxt = rd_ptr_q + 1'b1;

        wr_ptr_d = w_push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop_ok ? w_rd_ptr_nxt : rd_ptr_q;

        cnt_d = cnt_q;
        case ({w_push_ok, w_pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        hdr_out_d = hdr_out_q;
`ifdef WVB_STORAGE_HDR_FWFT_EN
        // Head register tracks the oldest entry; a push becomes the head when
        // it lands in an empty FIFO or replaces the last entry being popped.
        if (w_push_ok && (w_empty || (w_pop_ok && cnt_q == L_CNT_ONE))) begin
            hdr_out_d = bus.hdr_data_in;
        end else if (w_pop_ok && cnt_q > L_CNT_ONE) begin
            hdr_out_d = hdr_mem[w_rd_ptr_nxt];
        end
`else
        if (w_pop_ok) begin
            hdr_out_d = hdr_mem[rd_ptr_q];
        end
`endif

        // An error event in the same cycle as err_clr takes precedence.
        ovf_d  = w_push_drop ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
        unf_d  = w_pop_ign   ? 1'b1 : (bus.err_clr ? 1'b0 : unf_q);
        drop_d = bus.err_clr ? '0 : drop_q;
        if (w_push_drop) begin
            if (bus.err_clr) begin
                drop_d = 16'd1;
            end else if (drop_q != L_DROP_MAX) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            hdr_mem[wr_ptr_q] <= bus.hdr_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            hdr_out_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            hdr_out_q <= hdr_out_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.wvb_data_out    = wvb_rd_q;
    assign bus.hdr_data_out    = hdr_out_q;
    assign bus.hdr_full        = w_full;
    assign bus.hdr_empty       = w_empty;
    assign bus.hdr_almost_full = (32'(cnt_q) >= 32'(P_AFULL_THRESH));
    assign bus.n_wvf_in_buf    = P_N_WVF_IN_BUF_WIDTH'(cnt_q);
    assign bus.hdr_ovf         = ovf_q;
    assign bus.hdr_unf         = unf_q;
    assign bus.hdr_drop_cnt    = drop_q;
endmodule
`default_nettype wire

// File: doc/wvb_storage_gen2.md
Name: wvb_storage_gen2

Overview:
- Next-generation mDOM waveform buffer storage: inferred sample RAM plus inferred header FIFO, both depth-parametrised. No vendor IP cores.
- Sits between the waveform buffer write controller and the readout/DAQ reader.
- Adds over the previous generation:
  - arbitrary header-FIFO depth;
  - exact waveform count at any depth;
  - almost-full flag;
  - overflow/underflow error tracking with a dropped-header counter.

Parameters:
P_DATA_WIDTH, 22, sample word width; bit 0 is replaced by eoe_in.
P_ADR_WIDTH, 12, sample RAM address width (depth 2^P_ADR_WIDTH).
P_HDR_WIDTH, 80, header word width.
P_HDR_ADR_WIDTH, 8, header FIFO address width (depth D = 2^P_HDR_ADR_WIDTH).
P_N_WVF_IN_BUF_WIDTH, 16, width of n_wvf_in_buf; must be >= P_HDR_ADR_WIDTH+1, else elaboration error.
P_AFULL_THRESH, 240, hdr_almost_full asserts when count >= this value.

Ports:
clk  in  1  system clock, all logic rising-edge.
rst_n  in  1  asynchronous, active-low reset.
wvb_data_in  in  P_DATA_WIDTH  sample data in.
eoe_in  in  1  end-of-event marker, stored in bit 0.
wvb_wr_addr  in  P_ADR_WIDTH  sample write address.
wvb_wrreq  in  1  sample write enable.
wvb_rd_addr  in  P_ADR_WIDTH  sample read address.
wvb_data_out  out  P_DATA_WIDTH  registered sample read data.
hdr_data_in  in  P_HDR_WIDTH  header word in.
hdr_wrreq  in  1  header push.
hdr_rdreq  in  1  header pop.
hdr_data_out  out  P_HDR_WIDTH  header word out.
hdr_full  out  1  count == D.
hdr_empty  out  1  count == 0.
hdr_almost_full  out  1  count >= P_AFULL_THRESH.
n_wvf_in_buf  out  P_N_WVF_IN_BUF_WIDTH  header count, zero-extended.
hdr_ovf  out  1  sticky: push attempted while full.
hdr_unf  out  1  sticky: pop attempted while empty.
hdr_drop_cnt  out  16  dropped-header count, saturating.
err_clr  in  1  synchronous clear of hdr_ovf, hdr_unf, hdr_drop_cnt.

Behaviour:
Reset values (rst_n low, asynchronous):
- Header count, read pointer and write pointer = 0.
- hdr_empty=1, hdr_full=0, hdr_almost_full=0, n_wvf_in_buf=0.
- hdr_ovf=0, hdr_unf=0, hdr_drop_cnt=0.
- wvb_data_out=0, hdr_data_out=0.
- RAM contents are not reset.

Sample RAM:
- Written data word is {wvb_data_in[P_DATA_WIDTH-1:1], eoe_in}, stored at wvb_wr_addr when wvb_wrreq=1.
- Read latency is 1 clk: wvb_data_out reflects wvb_rd_addr sampled on the previous edge.
- Read and write to the same address in the same cycle returns the old data (read-first).

Header FIFO:
- Push is accepted when hdr_wrreq=1 and count<D.
- Pop is accepted when hdr_rdreq=1 and count>0.
- Pointers wrap modulo D.
- Simultaneous accepted push and pop: count unchanged.
- When full: a simultaneous push and pop accepts only the pop; the push is dropped.
- When empty: a simultaneous push and pop accepts only the push; the pop is ignored.
- Standard mode read: hdr_data_out updates 1 clk after an accepted pop and holds otherwise.
- Flags and n_wvf_in_buf are derived from the registered count and reflect an accepted operation on the next cycle.
- Exact count for all values 0..D; no special-casing of full.

Error tracking:
- Dropped push sets hdr_ovf and increments hdr_drop_cnt, saturating at 0xFFFF.
- Ignored pop sets hdr_unf.
- err_clr=1 clears the error state. If an error event occurs in the same cycle, the event wins: flag=1, hdr_drop_cnt=1 for a drop.
- Dropped or ignored operations never move pointers or count.

Optional Feature:
- Macro: WVB_STORAGE_HDR_FWFT_EN.
- Defined: header FIFO is first-word-fall-through. hdr_data_out presents the head entry whenever hdr_empty=0, including the cycle after the first push into an empty FIFO. An accepted pop advances to the next entry, valid on the following cycle. Head register reset value is 0.
- Undefined: standard mode as described above. hdr_rdreq acts as a read strobe with 1-clk latency.

Test Plan:
- RAM write/read with eoe: write 0x3FFFFE with eoe_in=1 to addr 0x005, read addr 0x005 -> wvb_data_out=0x3FFFFF one cycle after the address; same-cycle write 0x000010 / read of addr 0x005 -> old value 0x3FFFFF.
- Fill to full: D=256, push 256 headers with values 0..255 -> hdr_full=1 and n_wvf_in_buf=256; hdr_almost_full rises when count reaches 240; 257th push -> hdr_ovf=1, hdr_drop_cnt=1, count stays 256.
- Drain and wrap: pop all 256 in standard mode -> data 0..255 in order, each 1 clk after its pop, then hdr_empty=1; extra pop -> hdr_unf=1, hdr_data_out holds 255; then push 10 and pop 10 so pointers cross the wrap point -> order preserved.
- Simultaneous push/pop at count=5 -> count stays 5; at full -> pop accepted, push dropped, count=255, hdr_drop_cnt increments.
- Error clear: err_clr with no event -> hdr_ovf=0, hdr_unf=0, hdr_drop_cnt=0; err_clr coincident with a dropped push -> hdr_ovf=1, hdr_drop_cnt=1; 70000 dropped pushes -> hdr_drop_cnt=0xFFFF.
- Async reset mid-operation: rst_n low between clock edges with count=37 -> immediately count=0, hdr_empty=1, all error outputs 0; with WVB_STORAGE_HDR_FWFT_EN, one push of 0xABCD into an empty FIFO -> hdr_data_out=0xABCD next cycle with no pop issued.
